// File: rtl/tcb_pkg.sv
// Shared TCB interconnect types: arbitration mode, arbiter lock state and an index-width helper.
package tcb_pkg;

  typedef enum logic {TCB_ARB_RR, TCB_ARB_FIX} tcb_arb_mode_t;

  typedef enum logic {ARB_FREE, ARB_LOCK} tcb_arb_st_t;

  // Width of a port index; a single port still needs one bit to carry it.
  function automatic int tcb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcb_if.sv
// Tightly Coupled Bus point-to-point link: request/transfer phase plus delayed response.
interface tcb_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int DLY = 1
) ();
  logic          vld;
  logic          wen;
  logic [BW-1:0] ben;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdt;
  logic          rdy;
  logic [DW-1:0] rdt;
  logic          err;

  modport man (output vld, wen, ben, adr, wdt, input  rdy, rdt, err);
  modport sub (input  vld, wen, ben, adr, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_arb_rr.sv
// Rotating priority encoder: first requester at or above i_ptr, wrapping; i_ptr=0 gives fixed priority.
module tcb_arb_rr
  import tcb_pkg::*;
#(
  parameter int PN = 2,
  localparam int PW = tcb_idx_w(PN)
) (
  input  logic [PN-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PN-1:0] o_gnt,
  output logic [PW-1:0] o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < PN; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= PN) w_j = w_j - PN;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = PW'(w_j);
      end
    end
  end

endmodule

// File: rtl/tcb_arb.sv
// TCB arbiter: PN managers share one subordinate; grant is held through a stall and
// each response is steered back to its originator DLY cycles after the transfer.
module tcb_arb
  import tcb_pkg::*;
#(
  parameter int            AW   = 32,
  parameter int            DW   = 32,
  parameter int            BW   = DW/8,
  parameter int            DLY  = 1,
  parameter int            PN   = 2,
  parameter tcb_arb_mode_t MODE = TCB_ARB_RR
) (
  input  logic clk,
  input  logic rst,
  tcb_if.sub   sub [PN-1:0],
  tcb_if.man   man
);

  localparam int PW = tcb_idx_w(PN);

  logic [PN-1:0]         w_req;
  logic [PN-1:0]         w_wen;
  logic [PN-1:0][BW-1:0] w_ben;
  logic [PN-1:0][AW-1:0] w_adr;
  logic [PN-1:0][DW-1:0] w_wdt;
  logic [PN-1:0]         w_rdy;
  logic [PN-1:0]         w_rr_gnt;
  logic [PN-1:0]         w_goh;
  logic [PW-1:0]         w_rr_idx;
  logic [PW-1:0]         w_ptr_eff;
  logic [PW-1:0]         w_gidx;
  logic [PW-1:0]         w_ridx;
  logic [PW-1:0]         w_lidx_nxt;
  logic                  w_mvld;
  logic                  w_trn;
  logic                  w_lock;
  tcb_arb_st_t           w_state_nxt;

  tcb_arb_st_t           r_state;
  logic [PW-1:0]         r_lidx;
  logic [PW-1:0]         r_ptr;

  if (DLY < 0 || DLY > 4) begin : g_bad_dly
    $error("tcb_arb: DLY=%0d outside 0..4", DLY);
  end
  if (PN < 1) begin : g_bad_pn
    $error("tcb_arb: PN=%0d must be at least 1", PN);
  end
  if ($bits(man.adr) != AW || $bits(man.wdt) != DW || $bits(man.ben) != BW) begin : g_bad_man
    $error("tcb_arb: man port widths differ from arbiter AW/DW/BW");
  end

  for (genvar i = 0; i < PN; i++) begin : g_port
    if ($bits(sub[i].adr) != AW || $bits(sub[i].wdt) != DW || $bits(sub[i].ben) != BW) begin : g_bad_sub
      $error("tcb_arb: sub[%0d] widths differ from arbiter AW/DW/BW", i);
    end
    assign w_req[i]   = sub[i].vld;
    assign w_wen[i]   = sub[i].wen;
    assign w_ben[i]   = sub[i].ben;
    assign w_adr[i]   = sub[i].adr;
    assign w_wdt[i]   = sub[i].wdt;
    assign sub[i].rdy = w_rdy[i];
    // Non-target ports see zero so a stray response is never mistaken for real data.
    assign sub[i].rdt = (w_ridx == PW'(i)) ? man.rdt : '0;
    assign sub[i].err = (w_ridx == PW'(i)) ? man.err : 1'b0;
  end

  assign w_ptr_eff = (MODE == TCB_ARB_FIX) ? '0 : r_ptr;

  tcb_arb_rr #(.PN(PN)) u_rr (
    .i_req (w_req),
    .i_ptr (w_ptr_eff),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx)
  );

  assign w_lock = (r_state == ARB_LOCK);
  assign w_gidx = w_lock ? r_lidx : w_rr_idx;
  assign w_goh  = w_lock ? (PN'(1) << r_lidx) : w_rr_gnt;
  assign w_mvld = ~rst & (|(w_goh & w_req));
  assign w_trn  = w_mvld & man.rdy;
  assign w_rdy  = rst ? '0 : (w_goh & {PN{man.rdy}});

  assign man.vld = w_mvld;
  assign man.wen = w_wen[w_gidx];
  assign man.ben = w_ben[w_gidx];
  assign man.adr = w_adr[w_gidx];
  assign man.wdt = w_wdt[w_gidx];

  // A stalled request keeps its grant until it transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_lidx_nxt  = r_lidx;
    case (r_state)
      ARB_FREE: if (w_mvld && !man.rdy) begin
        w_state_nxt = ARB_LOCK;
        w_lidx_nxt  = w_gidx;
      end
      ARB_LOCK: if (w_trn) w_state_nxt = ARB_FREE;
      default:  w_state_nxt = ARB_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_FREE;
      r_lidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lidx  <= w_lidx_nxt;
      if (w_trn && MODE == TCB_ARB_RR)
        r_ptr <= (w_gidx == PW'(PN-1)) ? '0 : w_gidx + 1'b1;
    end
  end

  if (DLY == 0) begin : g_rsp_now
    assign w_ridx = w_gidx;
  end else begin : g_rsp_pipe
    logic [DLY-1:0][PW-1:0] r_sel;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sel <= '0;
      end else begin
        if (w_trn) r_sel[0] <= w_gidx;
        for (int k = 1; k < DLY; k++) r_sel[k] <= r_sel[k-1];
      end
    end
    assign w_ridx = r_sel[DLY-1];
  end

endmodule
